// File: rtl/simon_pkg.sv
// rtl/simon_pkg.sv - shared constants, types and word helpers for the SIMON64/128 engine
package simon_pkg;

    localparam int WORD_W    = 32;
    localparam int BLOCK_W   = 64;
    localparam int KEY_W     = 128;
    localparam int N_ROUNDS  = 44;
    localparam int KEY_WORDS = 4;

    localparam logic [WORD_W-1:0] C_CONST = 32'hFFFFFFFC;
    // Leftmost character is sequence index 0, so index i lives at bit 61-i.
    localparam logic [61:0] Z3 = 62'b11011011101011000110010111100000010010001010011100110100001111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    typedef logic [WORD_W-1:0] word_t;
    // Element 0 is the oldest word k_i, element 3 is k_i+3.
    typedef word_t [KEY_WORDS-1:0] key_win_t;

    function automatic word_t rol(input word_t w, input int s);
        return (w << s) | (w >> (WORD_W - s));
    endfunction

    function automatic word_t ror(input word_t w, input int s);
        return (w >> s) | (w << (WORD_W - s));
    endfunction

    function automatic word_t simon_f(input word_t x);
        return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
    endfunction

    function automatic logic z3_bit(input logic [5:0] idx);
        logic [5:0] m;
        m = (idx >= 6'd62) ? idx - 6'd62 : idx;
        return Z3[6'd61 - m];
    endfunction

endpackage

// File: rtl/simon64_encrypt_iter_if.sv
// rtl/simon64_encrypt_iter_if.sv - block-in / cipher-out handshake bundle for the encrypt engine
interface simon64_encrypt_iter_if;
    import simon_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [BLOCK_W-1:0] plain_text;
    logic [KEY_W-1:0]   key_seed;
    logic               out_valid;
    logic               out_ready;
    logic [BLOCK_W-1:0] cipher_text;
    logic               busy;

    modport master (
        output in_valid, plain_text, key_seed, out_ready,
        input  in_ready, out_valid, cipher_text, busy
    );

    modport slave (
        input  in_valid, plain_text, key_seed, out_ready,
        output in_ready, out_valid, cipher_text, busy
    );

endinterface

// File: rtl/simon64_key_step.sv
// rtl/simon64_key_step.sv - one on-the-fly key schedule step: slides the 4-word window by one word
module simon64_key_step
    import simon_pkg::*;
(
    input  key_win_t   win_in,
    input  logic [5:0] round_idx,
    output key_win_t   win_out
);

    word_t t;
    word_t k_new;

    always_comb begin
        t       = ror(win_in[3], 3) ^ win_in[1];
        k_new   = C_CONST ^ {{(WORD_W-1){1'b0}}, z3_bit(round_idx)} ^ win_in[0] ^ t ^ ror(t, 1);
        win_out = {k_new, win_in[3], win_in[2], win_in[1]};
    end

endmodule

// File: rtl/simon64_encrypt_iter.sv
// rtl/simon64_encrypt_iter.sv - iterative SIMON64/128 encryptor, UNROLL rounds per clock
module simon64_encrypt_iter
    import simon_pkg::*;
#(
    parameter int UNROLL = 1
) (
    input logic                   clk,
    input logic                   rst_n,
    simon64_encrypt_iter_if.slave bus
);

    if ((UNROLL < 1) || (UNROLL > N_ROUNDS) || ((N_ROUNDS % UNROLL) != 0)) begin : g_bad_unroll
        $error("simon64_encrypt_iter: UNROLL=%0d does not divide 44", UNROLL);
    end

    localparam int         N_CYC    = N_ROUNDS / UNROLL;
    localparam logic [5:0] LAST_CNT = 6'(N_CYC - 1);
    localparam logic [5:0] UNROLL_6 = 6'(UNROLL);

    state_t             state_q;
    state_t             state_d;
    logic [5:0]         cnt_q;
    word_t              x_q;
    word_t              y_q;
    key_win_t           key_q;
    logic [BLOCK_W-1:0] ct_q;

    word_t              xs   [UNROLL+1];
    word_t              ys   [UNROLL+1];
    key_win_t           wins [UNROLL+1];
    logic [5:0]         round_base;
    logic               accept;
    logic               last_cycle;

    assign accept     = (state_q == IDLE) && bus.in_valid;
    assign last_cycle = (state_q == RUN) && (cnt_q == LAST_CNT);
    assign round_base = cnt_q * UNROLL_6;

    assign xs[0]   = x_q;
    assign ys[0]   = y_q;
    assign wins[0] = key_q;

    // Each stage consumes k_i from the window head while the key step produces the next window.
    for (genvar u = 0; u < UNROLL; u++) begin : g_round
        simon64_key_step u_key_step (
            .win_in    (wins[u]),
            .round_idx (round_base + 6'(u)),
            .win_out   (wins[u+1])
        );
        assign xs[u+1] = ys[u] ^ simon_f(xs[u]) ^ wins[u][0];
        assign ys[u+1] = xs[u];
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.in_valid)  state_d = RUN;
            RUN:     if (cnt_q == LAST_CNT) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            key_q   <= '0;
            ct_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                x_q   <= bus.plain_text[BLOCK_W-1:WORD_W];
                y_q   <= bus.plain_text[WORD_W-1:0];
                key_q <= key_win_t'(bus.key_seed);
                cnt_q <= '0;
            end else if (state_q == RUN) begin
                x_q   <= xs[UNROLL];
                y_q   <= ys[UNROLL];
                key_q <= wins[UNROLL];
                // Parks at the terminal count until the next block is accepted.
                if (cnt_q != LAST_CNT) begin
                    cnt_q <= cnt_q + 6'd1;
                end
                if (last_cycle) begin
                    ct_q <= {xs[UNROLL], ys[UNROLL]};
                end
            end
        end
    end

    assign bus.in_ready    = (state_q == IDLE);
    assign bus.out_valid   = (state_q == DONE);
    assign bus.busy        = (state_q == RUN);
    assign bus.cipher_text = ct_q;

endmodule
